// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic arithmetic core and its LFSR.
package stoch_pkg;

  typedef enum logic [1:0] {
    MUL_UNI    = 2'd0,
    MUL_BIP    = 2'd1,
    ADD_SCALED = 2'd2,
    SQUARE     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned LFSR_W = 31;
  localparam int unsigned TAP_HI = 30;
  localparam int unsigned TAP_LO = 27;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 31'd134995;

endpackage

// File: rtl/stoch_lfsr.sv
// 31-bit Fibonacci LFSR (x^31+x^28+1) with synchronous reload and shift enable.
module stoch_lfsr
  import stoch_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (load) begin
      r_lfsr <= seed;
    end else if (en) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[TAP_LO] ^ r_lfsr[TAP_HI]};
    end
  end

  assign lfsr = r_lfsr;

endmodule

// File: rtl/stoch_arith_engine.sv
// Stochastic multiply/add/square core: one operand pair in, one 2^LOG_LEN-cycle
// LFSR-driven run, one WIDTH-bit estimate out over valid/ready handshakes.
module stoch_arith_engine
  import stoch_pkg::*;
#(
  parameter int unsigned       WIDTH   = 9,
  parameter int unsigned       LOG_LEN = 17,
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mode,
  input  logic             abort,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       res_mode
);

  state_e               r_state;
  logic                 r_in_ready;
  logic                 r_busy;
  logic                 r_res_valid;
  logic [WIDTH-1:0]     r_result;
  mode_e                r_res_mode;
  logic [WIDTH-1:0]     r_op_a;
  logic [WIDTH-1:0]     r_op_b;
  mode_e                r_mode;
  logic [LOG_LEN:0]     r_ones;
  logic [LOG_LEN-1:0]   r_cyc;
  logic                 r_sa_d;

  logic [LFSR_W-1:0]    w_lfsr;
  logic                 w_accept;
  logic                 w_sa;
  logic                 w_sb;
  logic                 w_sel;
  logic                 w_bit;
  logic [WIDTH-1:0]     w_estimate;

  assign w_accept = (r_state == S_IDLE) && in_valid;

  stoch_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_accept),
    .en    (r_state == S_RUN),
    .seed  (SEED),
    .lfsr  (w_lfsr)
  );

  always_comb begin
    w_sa  = w_lfsr[WIDTH-1:0] < r_op_a;
    w_sb  = w_lfsr[2*WIDTH-1:WIDTH] < r_op_b;
    w_sel = w_lfsr[TAP_HI];
    w_bit = 1'b0;
    case (r_mode)
      MUL_UNI:    w_bit = w_sa & w_sb;
      MUL_BIP:    w_bit = ~(w_sa ^ w_sb);
      ADD_SCALED: w_bit = w_sel ? w_sb : w_sa;
      SQUARE:     w_bit = w_sa & r_sa_d;
      default:    w_bit = 1'b0;
    endcase
  end

  // A full count (2^LOG_LEN) only sets the top bit; clamp instead of wrapping to 0.
  assign w_estimate = r_ones[LOG_LEN] ? '1 : r_ones[LOG_LEN-1 -: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_result    <= '0;
      r_res_mode  <= MUL_UNI;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_mode      <= MUL_UNI;
      r_ones      <= '0;
      r_cyc       <= '0;
      r_sa_d      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op_a     <= op_a;
            r_op_b     <= op_b;
            r_mode     <= mode_e'(mode);
            r_ones     <= '0;
            r_cyc      <= '0;
            r_sa_d     <= 1'b0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_ones <= r_ones + (LOG_LEN+1)'(w_bit);
            r_sa_d <= w_sa;
            r_cyc  <= r_cyc + 1'b1;
            if (r_cyc == '1) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          // First DONE cycle registers the estimate; handoff waits for res_valid.
          if (!r_res_valid) begin
            r_res_valid <= 1'b1;
            r_result    <= w_estimate;
            r_res_mode  <= r_mode;
          end else if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign result    = r_result;
  assign res_mode  = r_res_mode;

endmodule

// File: tb/tb_stoch_arith_engine.sv
// Directed bench for stoch_arith_engine at WIDTH=8, LOG_LEN=10.
module tb_stoch_arith_engine;

  localparam int unsigned W  = 8;
  localparam int unsigned LL = 10;
  localparam int unsigned N  = 1 << LL;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [1:0]   mode = '0;
  logic         abort = 1'b0;
  logic         busy;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] result;
  logic [1:0]   res_mode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stoch_arith_engine #(
    .WIDTH   (W),
    .LOG_LEN (LL),
    .SEED    (31'd134995)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .mode      (mode),
    .abort     (abort),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .res_mode  (res_mode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: independent walk of the LFSR stream from the reset seed.
  function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] m);
    logic [30:0] l;
    logic [LL:0] ones;
    logic        sa, sb, sad, bt;
    l = 31'd134995;
    ones = '0;
    sad = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      sa = l[7:0] < a;
      sb = l[15:8] < b;
      case (m)
        2'd0:    bt = sa & sb;
        2'd1:    bt = ~(sa ^ sb);
        2'd2:    bt = l[30] ? sb : sa;
        default: bt = sa & sad;
      endcase
      ones = ones + {{LL{1'b0}}, bt};
      sad = sa;
      l = {l[29:0], l[30] ^ l[27]};
    end
    return ones[LL] ? 8'd255 : ones[LL-1:LL-W];
  endfunction

  // Offer one job, wait for the result; lat counts clocks from the accept edge.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                         output logic [W-1:0] res, output logic [1:0] rm, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 3000) begin
      @(posedge clk); #1; g++;
    end
    op_a = a; op_b = b; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 3000) begin
      @(posedge clk); #1; lat++;
    end
    res = result;
    rm  = res_mode;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] r, r2, g, kept;
    logic [1:0]   rm;
    int           lat, d;
    bit           saw;

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_res_mode", res_mode, 0);

    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("idle_abort_ready", in_ready, 1);
    chk("idle_abort_busy", busy, 0);

    run_job(8'd0, 8'd0, 2'd1, r, rm, lat);
    chk("bip00_result", r, 255);
    chk("bip00_mode", rm, 1);
    chk("bip00_latency", lat, N + 1);

    run_job(8'd0, 8'd200, 2'd0, r, rm, lat);
    chk("uni0_result", r, 0);
    run_job(8'd0, 8'd0, 2'd2, r, rm, lat);
    chk("add00_result", r, 0);
    chk("add00_mode", rm, 2);
    run_job(8'd0, 8'd77, 2'd3, r, rm, lat);
    chk("sq0_result", r, 0);
    chk("sq0_mode", rm, 3);

    run_job(8'd128, 8'd128, 2'd0, r, rm, lat);
    chk("uni_half_golden", r, golden(8'd128, 8'd128, 2'd0));
    chk("uni_half_near64", (r >= 8'd58 && r <= 8'd70) ? 1 : 0, 1);
    run_job(8'd64, 8'd192, 2'd2, r, rm, lat);
    chk("add_golden", r, golden(8'd64, 8'd192, 2'd2));
    chk("add_near128", (r >= 8'd122 && r <= 8'd134) ? 1 : 0, 1);
    run_job(8'd64, 8'd192, 2'd2, r2, rm, lat);
    chk("back_to_back_same", r2, r);
    run_job(8'd200, 8'd0, 2'd3, r, rm, lat);
    chk("sq_golden", r, golden(8'd200, 8'd0, 2'd3));
    run_job(8'd100, 8'd30, 2'd1, r, rm, lat);
    chk("bip_golden", r, golden(8'd100, 8'd30, 2'd1));

    // Stall the consumer in DONE and try to push new work at it.
    g = golden(8'd128, 8'd128, 2'd0);
    res_ready = 1'b0;
    run_job(8'd128, 8'd128, 2'd0, r, rm, lat);
    chk("hold_first", r, g);
    for (int i = 0; i < 50; i++) begin
      in_valid = i[0];
      op_a = W'($urandom);
      op_b = W'($urandom);
      mode = 2'($urandom);
      @(posedge clk); #1;
      chk("hold_result", result, g);
      chk("hold_mode", res_mode, 0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", res_valid, 1);
    end
    op_a = 8'd128; op_b = 8'd128; mode = 2'd0; in_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_idle", in_ready, 1);
    chk("release_no_accept", busy, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("next_accept_busy", busy, 1);
    lat = 0;
    while (!res_valid && lat < 3000) begin
      @(posedge clk); #1; lat++;
    end
    chk("rerun_latency", lat, N + 1);
    chk("rerun_result", result, g);
    @(posedge clk); #1;

    // Abort at RUN cycle 300.
    kept = result;
    op_a = 8'd0; op_b = 8'd0; mode = 2'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 299; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_kept", result, kept);
    saw = 1'b0;
    for (int i = 0; i < int'(N) + 100; i++) begin
      @(posedge clk); #1;
      if (res_valid) saw = 1'b1;
    end
    chk("abort_no_valid", saw, 0);

    // Asynchronous reset in the middle of a run.
    op_a = 8'd0; op_b = 8'd0; mode = 2'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_res_mode", res_mode, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    d = 0;
    run_job(8'd0, 8'd0, 2'd1, r, rm, lat);
    chk("post_reset_result", r, 255);
    chk("post_reset_latency", lat + d, N + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
